// File: rtl/td4x_pkg.sv
// Shared definitions for the TD4-class core: opcodes, FSM states, datapath
// select codes and load-vector bit positions.
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_NOP0   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_NOP1   = 4'b1010;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_ADD_AB = 4'b1100;
  localparam logic [3:0] OP_HLT    = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  // ALU left operand
  typedef enum logic [1:0] {SEL_A, SEL_B, SEL_IN, SEL_ZERO} sel_e;

  // ALU right operand
  typedef enum logic [1:0] {ADDB_IM, ADDB_ZERO, ADDB_B} addb_e;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;
  localparam int LD_W   = 4;

endpackage

// File: rtl/td4x_decoder.sv
// Combinational instruction decoder: opcode and carry flag to register load
// enables, ALU operand selects and halt request.
module td4x_decoder
  import td4x_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic            cf_i,
  output logic [LD_W-1:0] ld_o,
  output sel_e            sel_o,
  output addb_e           addb_o,
  output logic            halt_o
);

  always_comb begin
    ld_o   = '0;
    sel_o  = SEL_ZERO;
    addb_o = ADDB_ZERO;
    halt_o = 1'b0;
    unique case (op_i)
      OP_ADD_A:  begin ld_o[LD_A] = 1'b1;   sel_o = SEL_A;  addb_o = ADDB_IM; end
      OP_MOV_AB: begin ld_o[LD_A] = 1'b1;   sel_o = SEL_B;  end
      OP_IN_A:   begin ld_o[LD_A] = 1'b1;   sel_o = SEL_IN; end
      OP_MOV_A:  begin ld_o[LD_A] = 1'b1;   addb_o = ADDB_IM; end
      OP_MOV_BA: begin ld_o[LD_B] = 1'b1;   sel_o = SEL_A;  end
      OP_ADD_B:  begin ld_o[LD_B] = 1'b1;   sel_o = SEL_B;  addb_o = ADDB_IM; end
      OP_IN_B:   begin ld_o[LD_B] = 1'b1;   sel_o = SEL_IN; end
      OP_MOV_B:  begin ld_o[LD_B] = 1'b1;   addb_o = ADDB_IM; end
      OP_OUT_B:  begin ld_o[LD_OUT] = 1'b1; sel_o = SEL_B;  end
      OP_OUT_IM: begin ld_o[LD_OUT] = 1'b1; addb_o = ADDB_IM; end
      OP_ADD_AB: begin ld_o[LD_A] = 1'b1;   sel_o = SEL_A;  addb_o = ADDB_B; end
      OP_HLT:    halt_o = 1'b1;
      // Jumps route 0+IM through the ALU so CF is always cleared by them
      OP_JMP:    begin ld_o[LD_PC] = 1'b1;  addb_o = ADDB_IM; end
      OP_JNC:    begin ld_o[LD_PC] = ~cf_i; addb_o = ADDB_IM; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// Parametrised TD4-class CPU core with wait-stated fetch, IN/OUT ports,
// output strobe and HALT/RESUME.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RST_PC = 0
) (
  input  logic              CLK,
  input  logic              RSTB,
  output logic [DATA_W-1:0] PC_ADDR,
  input  logic [DATA_W+3:0] INSTR,
  input  logic              INSTR_VALID,
  input  logic [DATA_W-1:0] IN_PORT,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              OUT_STB,
  input  logic              RESUME,
  output logic              HALTED
);

  localparam logic [DATA_W-1:0] PC_INIT = DATA_W'(RST_PC);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d, pc_q, pc_d;
  logic              cf_q, cf_d, stb_q, stb_d;
  state_e            state_q, state_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic [LD_W-1:0]   ld;
  sel_e              sel;
  addb_e             addb;
  logic              halt_req;
  logic              exec;
  logic [DATA_W-1:0] src_val, addb_val;
  logic [DATA_W:0]   sum;

  assign op   = INSTR[DATA_W+3:DATA_W];
  assign im   = INSTR[DATA_W-1:0];
  assign exec = (state_q == ST_RUN) && INSTR_VALID;

  td4x_decoder u_dec (
    .op_i   (op),
    .cf_i   (cf_q),
    .ld_o   (ld),
    .sel_o  (sel),
    .addb_o (addb),
    .halt_o (halt_req)
  );

  always_comb begin
    src_val  = '0;
    addb_val = '0;
    case (sel)
      SEL_A:   src_val = a_q;
      SEL_B:   src_val = b_q;
      SEL_IN:  src_val = IN_PORT;
      default: src_val = '0;
    endcase
    case (addb)
      ADDB_IM: addb_val = im;
      ADDB_B:  addb_val = b_q;
      default: addb_val = '0;
    endcase
  end

  assign sum = {1'b0, src_val} + {1'b0, addb_val};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    cf_d  = cf_q;
    stb_d = 1'b0;
    if (exec) begin
      if (ld[LD_A])   a_d   = sum[DATA_W-1:0];
      if (ld[LD_B])   b_d   = sum[DATA_W-1:0];
      if (ld[LD_OUT]) out_d = sum[DATA_W-1:0];
      pc_d  = ld[LD_PC] ? im : pc_q + DATA_W'(1);
      cf_d  = sum[DATA_W];
      stb_d = ld[LD_OUT];
    end
  end

  // A RESUME in the same cycle as HLT is ignored: state is still RUN then
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (exec && halt_req) state_d = ST_HALT;
      ST_HALT: if (RESUME)           state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      pc_q    <= PC_INIT;
      cf_q    <= 1'b0;
      stb_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      cf_q    <= cf_d;
      stb_q   <= stb_d;
      state_q <= state_d;
    end
  end

  assign PC_ADDR  = pc_q;
  assign OUT_PORT = out_q;
  assign OUT_STB  = stb_q;
  assign HALTED   = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4x_core.sv
// Directed bench for td4x_core: a 4-bit and an 8-bit instance, each fed from
// a small combinational ROM indexed by its PC.
module tb_td4x_core;

  logic        CLK;
  logic        RSTB;

  logic [3:0]  pc4, in4, out4;
  logic [7:0]  instr4;
  logic        valid4, stb4, resume4, hlt4;
  logic [7:0]  rom4 [16];

  logic [7:0]  pc8, in8, out8;
  logic [11:0] instr8;
  logic        valid8, stb8, resume8, hlt8;
  logic [11:0] rom8 [256];

  int pass_cnt;
  int total_cnt;

  assign instr4 = rom4[pc4];
  assign instr8 = rom8[pc8];

  td4x_core #(.DATA_W(4), .RST_PC(0)) u4 (
    .CLK(CLK), .RSTB(RSTB), .PC_ADDR(pc4), .INSTR(instr4), .INSTR_VALID(valid4),
    .IN_PORT(in4), .OUT_PORT(out4), .OUT_STB(stb4), .RESUME(resume4), .HALTED(hlt4)
  );

  td4x_core #(.DATA_W(8), .RST_PC(16)) u8 (
    .CLK(CLK), .RSTB(RSTB), .PC_ADDR(pc8), .INSTR(instr8), .INSTR_VALID(valid8),
    .IN_PORT(in8), .OUT_PORT(out8), .OUT_STB(stb8), .RESUME(resume8), .HALTED(hlt8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
    $display("t=%0t pc4=%h out4=%h stb4=%b hlt4=%b | pc8=%h out8=%h stb8=%b hlt8=%b",
             $time, pc4, out4, stb4, hlt4, pc8, out8, stb8, hlt8);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RSTB = 1'b0;
    #2;
    RSTB = 1'b1;
  endtask

  task automatic clear_rom4();
    for (int i = 0; i < 16; i++) rom4[i] = 8'h80;
  endtask

  task automatic load_arith();
    clear_rom4();
    rom4[0] = 8'h33; rom4[1] = 8'h05; rom4[2] = 8'h40; rom4[3] = 8'h90;
    rom4[4] = 8'h09; rom4[5] = 8'hE0; rom4[6] = 8'h40; rom4[7] = 8'h90;
    rom4[8] = 8'hE8;
  endtask

  task automatic test_reset();
    clear_rom4();
    rom4[0] = 8'hE3; rom4[3] = 8'h51; rom4[4] = 8'h90; rom4[5] = 8'h02;
    rom4[6] = 8'h40; rom4[7] = 8'h90; rom4[8] = 8'hF8;
    valid4 = 1'b1;
    @(negedge CLK);
    RSTB = 1'b0;
    #1;
    total_cnt++; if (pc4 !== 4'h0) $display("FAIL rst_pc4 got %h exp 0", pc4); else pass_cnt++;
    total_cnt++; if (out4 !== 4'h0) $display("FAIL rst_out4 got %h exp 0", out4); else pass_cnt++;
    total_cnt++; if (stb4 !== 1'b0) $display("FAIL rst_stb4 got %b exp 0", stb4); else pass_cnt++;
    total_cnt++; if (hlt4 !== 1'b0) $display("FAIL rst_hlt4 got %b exp 0", hlt4); else pass_cnt++;
    total_cnt++; if (pc8 !== 8'h10) $display("FAIL rst_pc8 got %h exp 10", pc8); else pass_cnt++;
    #1;
    RSTB = 1'b1;
    step();  // JNC 3 taken because CF resets to 0
    total_cnt++; if (pc4 !== 4'h3) $display("FAIL rst_cf_jnc got %h exp 3", pc4); else pass_cnt++;
    step(); step();  // ADD B,1 ; OUT B -> B was 0
    total_cnt++; if (out4 !== 4'h1) $display("FAIL rst_b got %h exp 1", out4); else pass_cnt++;
    step(); step(); step();  // ADD A,2 ; MOV B,A ; OUT B -> A was 0
    total_cnt++; if (out4 !== 4'h2) $display("FAIL rst_a got %h exp 2", out4); else pass_cnt++;
  endtask

  task automatic test_arith();
    load_arith();
    valid4 = 1'b1;
    apply_reset();
    step(); step(); step();
    total_cnt++; if (pc4 !== 4'h3) $display("FAIL arith_pc3 got %h exp 3", pc4); else pass_cnt++;
    step();  // OUT B with B = 3+5
    total_cnt++; if (out4 !== 4'h8) $display("FAIL arith_a8 got %h exp 8", out4); else pass_cnt++;
    total_cnt++; if (stb4 !== 1'b1) $display("FAIL arith_stb got %b exp 1", stb4); else pass_cnt++;
    step();  // ADD A,9 -> A=1, CF=1
    total_cnt++; if (stb4 !== 1'b0) $display("FAIL arith_stb_end got %b exp 0", stb4); else pass_cnt++;
    step();  // JNC 0 not taken
    total_cnt++; if (pc4 !== 4'h6) $display("FAIL arith_jnc_nt got %h exp 6", pc4); else pass_cnt++;
    step(); step();
    total_cnt++; if (out4 !== 4'h1) $display("FAIL arith_wrap got %h exp 1", out4); else pass_cnt++;
    step(); step();  // JNC 8 taken: CF cleared by preceding instructions
    total_cnt++; if (pc4 !== 4'h8) $display("FAIL arith_jnc_t got %h exp 8", pc4); else pass_cnt++;
  endtask

  task automatic test_wait();
    load_arith();
    valid4 = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      repeat (3) begin
        step();
        total_cnt++; if (pc4 !== 4'(i)) $display("FAIL wait_pc got %h exp %h", pc4, 4'(i)); else pass_cnt++;
        total_cnt++; if (stb4 !== 1'b0) $display("FAIL wait_stb got %b exp 0", stb4); else pass_cnt++;
      end
      valid4 = 1'b1;
      step();
      valid4 = 1'b0;
      if (i == 3) begin
        total_cnt++; if (out4 !== 4'h8) $display("FAIL wait_out8 got %h exp 8", out4); else pass_cnt++;
      end
    end
    total_cnt++; if (out4 !== 4'h1) $display("FAIL wait_out1 got %h exp 1", out4); else pass_cnt++;
    total_cnt++; if (pc4 !== 4'h8) $display("FAIL wait_pc8 got %h exp 8", pc4); else pass_cnt++;
  endtask

  task automatic test_out();
    clear_rom4();
    rom4[0] = 8'hB7; rom4[1] = 8'h72; rom4[2] = 8'h90; rom4[3] = 8'h90; rom4[4] = 8'hF4;
    valid4 = 1'b1;
    apply_reset();
    step();
    total_cnt++; if (out4 !== 4'h7) $display("FAIL out_im got %h exp 7", out4); else pass_cnt++;
    total_cnt++; if (stb4 !== 1'b1) $display("FAIL out_im_stb got %b exp 1", stb4); else pass_cnt++;
    step();
    total_cnt++; if (stb4 !== 1'b0) $display("FAIL out_im_stb_end got %b exp 0", stb4); else pass_cnt++;
    step();
    total_cnt++; if (out4 !== 4'h2) $display("FAIL out_b got %h exp 2", out4); else pass_cnt++;
    total_cnt++; if (stb4 !== 1'b1) $display("FAIL out_b2b_1 got %b exp 1", stb4); else pass_cnt++;
    step();
    total_cnt++; if (stb4 !== 1'b1) $display("FAIL out_b2b_2 got %b exp 1", stb4); else pass_cnt++;
    step();
    total_cnt++; if (stb4 !== 1'b0) $display("FAIL out_b2b_end got %b exp 0", stb4); else pass_cnt++;
    step();
    total_cnt++; if (pc4 !== 4'h4) $display("FAIL out_jmp got %h exp 4", pc4); else pass_cnt++;
  endtask

  task automatic test_in_addab();
    clear_rom4();
    rom4[0] = 8'h20; rom4[1] = 8'h60; rom4[2] = 8'hCF; rom4[3] = 8'hE0;
    rom4[4] = 8'h40; rom4[5] = 8'h90; rom4[6] = 8'hF6;
    valid4 = 1'b1;
    in4 = 4'h6;
    apply_reset();
    step();  // IN A = 6
    in4 = 4'hB;
    step();  // IN B = 11
    in4 = 4'h0;
    step();  // ADD A,B = 17 -> 1, CF=1; IM must be ignored
    step();  // JNC not taken
    total_cnt++; if (pc4 !== 4'h4) $display("FAIL addab_cf got %h exp 4", pc4); else pass_cnt++;
    step(); step();
    total_cnt++; if (out4 !== 4'h1) $display("FAIL addab_sum got %h exp 1", out4); else pass_cnt++;
  endtask

  task automatic test_halt();
    clear_rom4();
    rom4[5] = 8'hD0; rom4[6] = 8'hB9; rom4[7] = 8'hD0; rom4[8] = 8'hF8;
    valid4 = 1'b1;
    resume4 = 1'b0;
    apply_reset();
    repeat (5) step();
    total_cnt++; if (hlt4 !== 1'b0) $display("FAIL halt_pre got %b exp 0", hlt4); else pass_cnt++;
    step();
    total_cnt++; if (hlt4 !== 1'b1) $display("FAIL halt_set got %b exp 1", hlt4); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      step();
      total_cnt++; if (pc4 !== 4'h6) $display("FAIL halt_pc got %h exp 6", pc4); else pass_cnt++;
      total_cnt++; if (hlt4 !== 1'b1) $display("FAIL halt_hold got %b exp 1", hlt4); else pass_cnt++;
    end
    resume4 = 1'b1;
    step();
    resume4 = 1'b0;
    total_cnt++; if (hlt4 !== 1'b0) $display("FAIL resume_hlt got %b exp 0", hlt4); else pass_cnt++;
    total_cnt++; if (pc4 !== 4'h6) $display("FAIL resume_pc got %h exp 6", pc4); else pass_cnt++;
    step();
    total_cnt++; if (out4 !== 4'h9) $display("FAIL resume_exec got %h exp 9", out4); else pass_cnt++;
    resume4 = 1'b1;
    step();  // HLT with RESUME high: halts anyway
    total_cnt++; if (hlt4 !== 1'b1) $display("FAIL hlt_wins got %b exp 1", hlt4); else pass_cnt++;
    total_cnt++; if (pc4 !== 4'h8) $display("FAIL hlt_wins_pc got %h exp 8", pc4); else pass_cnt++;
    step();
    resume4 = 1'b0;
    total_cnt++; if (hlt4 !== 1'b0) $display("FAIL hlt_resume2 got %b exp 0", hlt4); else pass_cnt++;
  endtask

  task automatic test_reset_async();
    clear_rom4();
    rom4[0] = 8'hB7; rom4[1] = 8'hD0; rom4[2] = 8'hF2;
    valid4 = 1'b1;
    resume4 = 1'b0;
    apply_reset();
    step();
    valid4 = 1'b0;
    step();  // waiting with OUT=7, PC=1
    #1;
    RSTB = 1'b0;
    #1;
    total_cnt++; if (out4 !== 4'h0) $display("FAIL arst_wait_out got %h exp 0", out4); else pass_cnt++;
    total_cnt++; if (pc4 !== 4'h0) $display("FAIL arst_wait_pc got %h exp 0", pc4); else pass_cnt++;
    #1;
    RSTB = 1'b1;
    valid4 = 1'b1;
    step();  // OUT strobe high; reset must kill it immediately
    RSTB = 1'b0;
    #1;
    total_cnt++; if (stb4 !== 1'b0) $display("FAIL arst_stb got %b exp 0", stb4); else pass_cnt++;
    #1;
    RSTB = 1'b1;
    step(); step();
    total_cnt++; if (hlt4 !== 1'b1) $display("FAIL arst_halt_pre got %b exp 1", hlt4); else pass_cnt++;
    #1;
    RSTB = 1'b0;
    #1;
    total_cnt++; if (hlt4 !== 1'b0) $display("FAIL arst_halt got %b exp 0", hlt4); else pass_cnt++;
    total_cnt++; if (pc4 !== 4'h0) $display("FAIL arst_halt_pc got %h exp 0", pc4); else pass_cnt++;
    total_cnt++; if (out4 !== 4'h0) $display("FAIL arst_halt_out got %h exp 0", out4); else pass_cnt++;
    total_cnt++; if (pc8 !== 8'h10) $display("FAIL arst_pc8 got %h exp 10", pc8); else pass_cnt++;
    #1;
    RSTB = 1'b1;
  endtask

  task automatic test_w8();
    for (int i = 0; i < 256; i++) rom8[i] = 12'h800;
    rom8[8'h10] = 12'h301; rom8[8'h11] = 12'h0FF; rom8[8'h12] = 12'hE40;
    rom8[8'h13] = 12'h400; rom8[8'h14] = 12'h55A; rom8[8'h15] = 12'h900;
    rom8[8'h16] = 12'hFFF; rom8[8'h00] = 12'hBC3; rom8[8'h01] = 12'hF01;
    valid4 = 1'b0;
    valid8 = 1'b1;
    apply_reset();
    step(); step(); step();  // MOV A,1 ; ADD A,FF -> 0 CF=1 ; JNC not taken
    total_cnt++; if (pc8 !== 8'h13) $display("FAIL w8_carry got %h exp 13", pc8); else pass_cnt++;
    step(); step(); step();  // B=A=0 ; B+=5A ; OUT B
    total_cnt++; if (out8 !== 8'h5A) $display("FAIL w8_zero got %h exp 5a", out8); else pass_cnt++;
    step();
    total_cnt++; if (pc8 !== 8'hFF) $display("FAIL w8_jmp got %h exp ff", pc8); else pass_cnt++;
    step();
    total_cnt++; if (pc8 !== 8'h00) $display("FAIL w8_wrap got %h exp 00", pc8); else pass_cnt++;
    step();
    total_cnt++; if (out8 !== 8'hC3) $display("FAIL w8_out got %h exp c3", out8); else pass_cnt++;
    total_cnt++; if (stb8 !== 1'b1) $display("FAIL w8_stb got %b exp 1", stb8); else pass_cnt++;
    valid8 = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RSTB    = 1'b1;
    valid4  = 1'b0;
    valid8  = 1'b0;
    in4     = '0;
    in8     = '0;
    resume4 = 1'b0;
    resume8 = 1'b0;
    clear_rom4();
    for (int i = 0; i < 256; i++) rom8[i] = 12'h800;
    test_reset();
    test_arith();
    test_wait();
    test_out();
    test_in_addab();
    test_halt();
    test_reset_async();
    test_w8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
